chrono_counter: RTL and testbench

Time-base and counting core of the start/stop/lap/reset chronometer, directly downstream of the button-driven state machine. Consumes the 3-bit chronometer state and the `reset_pulse` level, divides the system clock into 10 ms ticks, and keeps a BCD MM:SS.cc count. It also holds a separately latched display copy that freezes in lap states, and flags each display change to the LCD driver.

---
 rtl/chrono_counter.sv | 120 ++++++++++++
 tb/tb_chrono_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_counter.sv
// Time base and BCD MM:SS.cc counter for the chronometer, with a lap-freezable
// display copy and a strobe that tells the LCD driver when the display changed.
module chrono_counter #(
  parameter int unsigned TICK_DIV = 120000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [2:0] state,
  input  logic       reset_pulse,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] cs_t,
  output logic [3:0] cs_u,
  output logic       disp_update,
  output logic       ovf
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_ZERO       = 3'd0,
    ST_PAUSED     = 3'd1,
    ST_RUN        = 3'd2,
    ST_LAP        = 3'd3,
    ST_LAP_PAUSED = 3'd4
  } chrono_state_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } bcd_time_t;

  // Returns {carry_out, next_digit} for one stage of the BCD chain.
  function automatic logic [4:0] dig_step(input logic [3:0] d,
                                          input logic [3:0] max_val,
                                          input logic       cin);
    if (!cin)          return {1'b0, d};
    if (d == max_val)  return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  bcd_time_t     cnt_q, cnt_d;
  bcd_time_t     disp_q, disp_d;
  logic          disp_update_q, disp_update_d;
  logic          ovf_q, ovf_d;

  logic          run, frozen, tick;
  logic [4:0]    s_cs_u, s_cs_t, s_sec_u, s_sec_t, s_min_u, s_min_t;

  // NOTE: every variable gets a default at the top of the block, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    run           = (state == ST_RUN) || (state == ST_LAP);
    frozen        = (state == ST_LAP) || (state == ST_LAP_PAUSED);
    tick          = run && (presc_q == PRESC_LAST);

    presc_d       = presc_q;
    if (run) presc_d = tick ? '0 : presc_q + PW'(1);

    s_cs_u  = dig_step(cnt_q.cs_u,  4'd9, tick);
    s_cs_t  = dig_step(cnt_q.cs_t,  4'd9, s_cs_u[4]);
    s_sec_u = dig_step(cnt_q.sec_u, 4'd9, s_cs_t[4]);
    s_sec_t = dig_step(cnt_q.sec_t, 4'd5, s_sec_u[4]);
    s_min_u = dig_step(cnt_q.min_u, 4'd9, s_sec_t[4]);
    s_min_t = dig_step(cnt_q.min_t, 4'd5, s_min_u[4]);

    cnt_d   = '{min_t: s_min_t[3:0], min_u: s_min_u[3:0],
                sec_t: s_sec_t[3:0], sec_u: s_sec_u[3:0],
                cs_t:  s_cs_t[3:0],  cs_u:  s_cs_u[3:0]};
    ovf_d   = ovf_q | s_min_t[4];

    // The display lags the count by one cycle and holds while in a lap state.
    disp_d  = frozen ? disp_q : cnt_q;

    if (reset_pulse) begin
      presc_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      disp_d  = '0;
    end

    disp_update_d = (disp_d != disp_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      disp_q        <= '0;
      disp_update_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      disp_q        <= disp_d;
      disp_update_q <= disp_update_d;
      ovf_q         <= ovf_d;
    end
  end

  assign min_t       = disp_q.min_t;
  assign min_u       = disp_q.min_u;
  assign sec_t       = disp_q.sec_t;
  assign sec_u       = disp_q.sec_u;
  assign cs_t        = disp_q.cs_t;
  assign cs_u        = disp_q.cs_u;
  assign disp_update = disp_update_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_chrono_counter.sv
// Directed bench for chrono_counter: stimulus queues the expected display value
// of every disp_update strobe; a monitor pops and compares each strobe.
module tb_chrono_counter;

  logic       clk_in;
  logic       rst_n_in;
  logic [2:0] state;
  logic       reset_pulse;
  logic [3:0] min_t, min_u, sec_t, sec_u, cs_t, cs_u;
  logic       disp_update;
  logic       ovf;

  chrono_counter #(.TICK_DIV(4)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .state       (state),
    .reset_pulse (reset_pulse),
    .min_t       (min_t),
    .min_u       (min_u),
    .sec_t       (sec_t),
    .sec_u       (sec_u),
    .cs_t        (cs_t),
    .cs_u        (cs_u),
    .disp_update (disp_update),
    .ovf         (ovf)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [23:0] sb[$];
  logic [23:0] disp_w;

  assign disp_w = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected display digits for a count of n centiseconds.
  function automatic logic [23:0] exp_disp(input int n);
    int c, s, m;
    c = n % 100;
    s = (n / 100) % 60;
    m = (n / 6000) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) sb.push_back(exp_disp(n));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic expect_drained(input string name);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every strobe must match the next queued display value.
  always @(negedge clk_in) begin
    if (disp_update === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: display %h, no strobe expected", disp_w);
      end else begin
        check("strobe_value", 32'(disp_w), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst_n_in    = 1'b0;
    state       = 3'd2;
    reset_pulse = 1'b0;
    cyc(3);
    check("rst_digits", 32'(disp_w), 32'd0);
    check("rst_update", 32'(disp_update), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Tick rate: 40 running cycles give 10 ticks and 10 strobes.
    rst_n_in = 1'b1;
    state    = 3'd0;
    cyc(1);
    check("post_rst_digits", 32'(disp_w), 32'd0);
    check("post_rst_update", 32'(disp_update), 32'd0);
    push_range(1, 10);
    state = 3'd2;
    cyc(40);
    state = 3'd1;
    cyc(1);
    check("rate_disp", 32'(disp_w), 32'(exp_disp(10)));
    cyc(2);
    expect_drained("rate_strobes");

    // Pause keeps the prescaler phase.
    reset_pulse = 1'b1;
    sb.push_back(exp_disp(0));
    cyc(1);
    reset_pulse = 1'b0;
    push_range(1, 1);
    state = 3'd2;
    cyc(6);
    state = 3'd1;
    cyc(20);
    check("pause_disp", 32'(disp_w), 32'(exp_disp(1)));
    expect_drained("pause_strobes");
    push_range(2, 5);
    state = 3'd2;
    cyc(2);
    check("resume_before_tick", 32'(disp_w), 32'(exp_disp(1)));
    cyc(1);
    check("resume_after_tick", 32'(disp_w), 32'(exp_disp(2)));
    cyc(12);
    check("count_to_5", 32'(disp_w), 32'(exp_disp(5)));

    // Lap freeze: display holds 5 while the count reaches 10.
    state = 3'd3;
    cyc(20);
    check("lap_frozen", 32'(disp_w), 32'(exp_disp(5)));
    expect_drained("lap_no_strobe");
    push_range(10, 10);
    state = 3'd2;
    cyc(1);
    check("lap_release", 32'(disp_w), 32'(exp_disp(10)));
    expect_drained("lap_release_strobe");

    // Lap-paused to paused: display 5, count 8.
    state       = 3'd1;
    reset_pulse = 1'b1;
    sb.push_back(exp_disp(0));
    cyc(1);
    reset_pulse = 1'b0;
    push_range(1, 5);
    state = 3'd2;
    cyc(21);
    check("lp_setup", 32'(disp_w), 32'(exp_disp(5)));
    state = 3'd3;
    cyc(12);
    state = 3'd4;
    cyc(3);
    check("lp_frozen", 32'(disp_w), 32'(exp_disp(5)));
    expect_drained("lp_no_strobe");
    push_range(8, 8);
    state = 3'd1;
    cyc(1);
    check("lp_to_paused", 32'(disp_w), 32'(exp_disp(8)));
    cyc(5);
    check("paused_hold", 32'(disp_w), 32'(exp_disp(8)));
    expect_drained("lp_strobes");

    // Overflow from a preloaded 59:59.99.
    reset_pulse = 1'b1;
    sb.push_back(exp_disp(0));
    cyc(1);
    reset_pulse = 1'b0;
    sb.push_back(24'h595999);
    force dut.cnt_q = 24'h595999;
    cyc(1);
    release dut.cnt_q;
    check("preload_disp", 32'(disp_w), 32'h595999);
    sb.push_back(exp_disp(0));
    state = 3'd2;
    cyc(3);
    check("ovf_before_wrap", 32'(ovf), 32'd0);
    cyc(1);
    check("ovf_on_wrap", 32'(ovf), 32'd1);
    cyc(1);
    check("wrap_disp", 32'(disp_w), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    cyc(1);
    reset_pulse = 1'b1;
    cyc(1);
    check("pulse_clears_ovf", 32'(ovf), 32'd0);
    check("pulse_digits", 32'(disp_w), 32'd0);

    // Tick coincident with reset_pulse: reset wins.
    reset_pulse = 1'b0;
    cyc(3);
    reset_pulse = 1'b1;
    cyc(1);
    reset_pulse = 1'b0;
    state       = 3'd1;
    cyc(2);
    check("tick_vs_pulse", 32'(disp_w), 32'd0);
    expect_drained("ovf_strobes");

    // rst_n_in beats running at 00:01.23.
    push_range(1, 123);
    state = 3'd2;
    cyc(493);
    check("count_123", 32'(disp_w), 32'(exp_disp(123)));
    rst_n_in = 1'b0;
    cyc(1);
    check("midrun_rst_digits", 32'(disp_w), 32'd0);
    check("midrun_rst_update", 32'(disp_update), 32'd0);
    check("midrun_rst_ovf", 32'(ovf), 32'd0);
    cyc(1);
    rst_n_in = 1'b1;

    // Invalid states 5..7 mean stopped.
    for (int s = 5; s <= 7; s++) begin
      state = 3'(s);
      cyc(6);
    end
    check("invalid_stopped", 32'(disp_w), 32'd0);
    expect_drained("invalid_strobes");

    // Seconds-to-minutes carry: 6000 ticks reach 01:00.00.
    push_range(1, 6000);
    state = 3'd2;
    cyc(24001);
    check("minute_carry", 32'(disp_w), 32'h010000);
    state = 3'd1;
    cyc(2);
    expect_drained("carry_strobes");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
